// File: rtl/axis_ptt_sequencer.sv
// Packet-aware push-to-talk sequencer for the TX AXI4-Stream path.
// The stream passes through combinationally; only the state that gates it is registered.
module axis_ptt_sequencer #(
  parameter int DATA_WIDTH   = 16,
  parameter int CNT_WIDTH    = 32,
  parameter int KEYUP_CYCLES = 1000,
  parameter int TAIL_CYCLES  = 500,
  parameter int TOT_CYCLES   = 0
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  ptt_en,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic                  rf_key,
  output logic                  tot_expired,
  output logic [2:0]            state_o
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_KEYUP   = 3'd1,
    S_PASS    = 3'd2,
    S_DRAIN   = 3'd3,
    S_TAIL    = 3'd4,
    S_LOCKOUT = 3'd5
  } state_t;

  localparam logic [CNT_WIDTH-1:0] KEYUP_LAST = CNT_WIDTH'(KEYUP_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] TAIL_LEN   = CNT_WIDTH'(TAIL_CYCLES);
  localparam logic [CNT_WIDTH-1:0] TOT_LAST   = CNT_WIDTH'(TOT_CYCLES - 1);

  state_t               state;
  state_t               state_nxt;
  logic [CNT_WIDTH-1:0] cnt;
  logic                 in_pkt;
  logic                 open;
  logic                 xfer;
  logic                 pkt_open_nxt;
  logic                 tot_hit;
  logic                 tot_set;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_WIDTH'(1);
  endfunction

  // State register: FSM state, shared counter, registered rf_key and sticky flags
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state       <= S_IDLE;
      cnt         <= '0;
      rf_key      <= 1'b0;
      tot_expired <= 1'b0;
      in_pkt      <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= (state_nxt != state) ? '0 : sat_inc(cnt);
      rf_key <= state_nxt inside {S_KEYUP, S_PASS, S_DRAIN, S_TAIL};
      if (state_nxt == S_IDLE)
        tot_expired <= 1'b0;
      else if (tot_set)
        tot_expired <= 1'b1;
      if (xfer)
        in_pkt <= ~s_axis_tlast;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt    = state;
    tot_set      = 1'b0;
    tot_hit      = (TOT_CYCLES != 0) && (cnt == TOT_LAST);
    // Whether a packet is still open once this cycle's beat (if any) has moved;
    // a packet that starts in the release cycle is drained rather than cut.
    pkt_open_nxt = xfer ? ~s_axis_tlast : in_pkt;
    case (state)
      S_IDLE:    if (ptt_en) state_nxt = S_KEYUP;
      S_KEYUP: begin
        if (!ptt_en)
          state_nxt = S_TAIL;
        else if (cnt == KEYUP_LAST)
          state_nxt = S_PASS;
      end
      S_PASS: begin
        if (!ptt_en || tot_hit) begin
          tot_set   = tot_hit;
          state_nxt = pkt_open_nxt ? S_DRAIN : S_TAIL;
        end
      end
      S_DRAIN:   if (xfer && s_axis_tlast) state_nxt = S_TAIL;
      S_TAIL: begin
        if (ptt_en && !tot_expired)
          state_nxt = S_PASS;
        else if (cnt >= TAIL_LEN)
          state_nxt = tot_expired ? S_LOCKOUT : S_IDLE;
      end
      S_LOCKOUT: if (!ptt_en) state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // Output logic: stream gating and zero-latency pass-through
  always_comb begin
    open          = (state == S_PASS) || (state == S_DRAIN);
    xfer          = s_axis_tvalid & m_axis_tready & open;
    m_axis_tvalid = open & s_axis_tvalid;
    s_axis_tready = open & m_axis_tready;
    m_axis_tdata  = s_axis_tdata;
    m_axis_tlast  = s_axis_tlast;
    state_o       = state;
  end

endmodule

// File: tb/tb_axis_ptt_sequencer.sv
// Bench for axis_ptt_sequencer: vector table, directed multi-cycle sequences and
// randomized traffic against a phase/age reference model.
module tb_axis_ptt_sequencer;

  localparam int DW    = 16;
  localparam int CW    = 32;
  localparam int KEYUP = 4;
  localparam int TAIL  = 3;
  localparam int TOT   = 20;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic          ptt_en = 1'b0;
  logic [DW-1:0] s_axis_tdata = '0;
  logic          s_axis_tvalid = 1'b0;
  logic          s_axis_tready;
  logic          s_axis_tlast = 1'b0;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tready = 1'b0;
  logic          m_axis_tlast;
  logic          rf_key;
  logic          tot_expired;
  logic [2:0]    state_o;

  int checks = 0;
  int failures = 0;

  axis_ptt_sequencer #(
    .DATA_WIDTH(DW), .CNT_WIDTH(CW), .KEYUP_CYCLES(KEYUP),
    .TAIL_CYCLES(TAIL), .TOT_CYCLES(TOT)
  ) dut (
    .aclk(aclk), .aresetn(aresetn), .ptt_en(ptt_en),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
    .rf_key(rf_key), .tot_expired(tot_expired), .state_o(state_o)
  );

  always #5 aclk = ~aclk;

  // Reference model: phase number, cycles spent in the phase, sticky TOT flag, open packet
  int m_phase = 0;
  int m_age = 0;
  bit m_tot = 1'b0;
  bit m_inpkt = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_age = 0; m_tot = 1'b0; m_inpkt = 1'b0;
  endtask

  task automatic model_step();
    bit open, xfer, pkt_after, fire;
    int nxt;
    open      = (m_phase == 2) || (m_phase == 3);
    xfer      = s_axis_tvalid && m_axis_tready && open;
    pkt_after = xfer ? !s_axis_tlast : m_inpkt;
    fire      = 1'b0;
    nxt       = m_phase;
    case (m_phase)
      0: if (ptt_en) nxt = 1;
      1: if (!ptt_en) nxt = 4; else if (m_age + 1 >= KEYUP) nxt = 2;
      2: begin
        fire = (TOT != 0) && (m_age + 1 == TOT);
        if (fire) m_tot = 1'b1;
        if (!ptt_en || fire) nxt = pkt_after ? 3 : 4;
      end
      3: if (xfer && s_axis_tlast) nxt = 4;
      4: if (ptt_en && !m_tot) nxt = 2; else if (m_age >= TAIL) nxt = m_tot ? 5 : 0;
      5: if (!ptt_en) nxt = 0;
      default: nxt = 0;
    endcase
    if (xfer) m_inpkt = !s_axis_tlast;
    if (nxt == 0 && m_phase != 0) m_tot = 1'b0;
    m_age   = (nxt != m_phase) ? 0 : m_age + 1;
    m_phase = nxt;
  endtask

  task automatic check_model();
    bit open;
    open = (m_phase == 2) || (m_phase == 3);
    chk("model.state", 32'(state_o), 32'(m_phase));
    chk("model.rf_key", 32'(rf_key), 32'(m_phase >= 1 && m_phase <= 4));
    chk("model.tot_expired", 32'(tot_expired), 32'(m_tot));
    chk("model.m_tvalid", 32'(m_axis_tvalid), 32'(open && s_axis_tvalid));
    chk("model.s_tready", 32'(s_axis_tready), 32'(open && m_axis_tready));
    chk("model.m_tdata", 32'(m_axis_tdata), 32'(s_axis_tdata));
    chk("model.m_tlast", 32'(m_axis_tlast), 32'(s_axis_tlast));
  endtask

  task automatic drive(input logic p, input logic tv, input logic tl, input logic tr,
                       input logic [DW-1:0] d);
    @(negedge aclk);
    ptt_en = p; s_axis_tvalid = tv; s_axis_tlast = tl; m_axis_tready = tr; s_axis_tdata = d;
    #1;
    check_model();
  endtask

  task automatic tick();
    @(posedge aclk);
    model_step();
  endtask

  task automatic do_reset();
    @(negedge aclk);
    aresetn = 1'b0; ptt_en = 1'b1; s_axis_tvalid = 1'b1; m_axis_tready = 1'b1; s_axis_tlast = 1'b0;
    model_reset();
    #1;
    chk("reset.rf_key", 32'(rf_key), 32'd0);
    chk("reset.m_tvalid", 32'(m_axis_tvalid), 32'd0);
    chk("reset.s_tready", 32'(s_axis_tready), 32'd0);
    chk("reset.state", 32'(state_o), 32'd0);
    chk("reset.tot_expired", 32'(tot_expired), 32'd0);
    @(negedge aclk);
    aresetn = 1'b1; ptt_en = 1'b0; s_axis_tvalid = 1'b0; m_axis_tready = 1'b0;
    tick();
  endtask

  typedef struct {
    logic       ptt, tv, tl, tr;
    logic       rf;
    logic [2:0] st;
    logic       mv, sr;
  } vec_t;

  vec_t tbl[21];

  function automatic int tot_seq_state(input int c);
    if (c == 0)  return 0;
    if (c <= 4)  return 1;
    if (c <= 24) return 2;
    if (c <= 36) return 3;
    if (c <= 40) return 4;
    if (c <= 46) return 5;
    return 0;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int beat, passed, up_beats, dn_beats;
    logic p, tv, tl, tr, acc, hold_prev;
    logic [DW-1:0] d, hold_data;

    // ptt, tvalid, tlast, tready | rf_key, state, m_tvalid, s_tready
    tbl[0]  = '{1,1,0,1, 0,3'd0,0,0};
    tbl[1]  = '{1,1,0,1, 1,3'd1,0,0};
    tbl[2]  = '{1,1,0,1, 1,3'd1,0,0};
    tbl[3]  = '{1,1,0,1, 1,3'd1,0,0};
    tbl[4]  = '{1,1,0,1, 1,3'd1,0,0};
    tbl[5]  = '{1,1,0,1, 1,3'd2,1,1};
    tbl[6]  = '{1,1,0,0, 1,3'd2,1,0};
    tbl[7]  = '{0,1,0,1, 1,3'd2,1,1};
    tbl[8]  = '{0,0,0,1, 1,3'd3,0,1};
    tbl[9]  = '{1,1,1,1, 1,3'd3,1,1};
    tbl[10] = '{0,1,0,1, 1,3'd4,0,0};
    tbl[11] = '{0,0,0,0, 1,3'd4,0,0};
    tbl[12] = '{0,0,0,0, 1,3'd4,0,0};
    tbl[13] = '{0,0,0,0, 1,3'd4,0,0};
    tbl[14] = '{0,0,0,0, 0,3'd0,0,0};
    tbl[15] = '{1,0,0,0, 0,3'd0,0,0};
    tbl[16] = '{0,0,0,0, 1,3'd1,0,0};
    tbl[17] = '{0,0,0,0, 1,3'd4,0,0};
    tbl[18] = '{1,0,0,0, 1,3'd4,0,0};
    tbl[19] = '{0,0,0,1, 1,3'd2,0,1};
    tbl[20] = '{0,0,0,1, 1,3'd4,0,0};

    do_reset();
    for (int i = 0; i < 21; i++) begin
      drive(tbl[i].ptt, tbl[i].tv, tbl[i].tl, tbl[i].tr, DW'($urandom));
      chk($sformatf("vec%0d.state", i), 32'(state_o), 32'(tbl[i].st));
      chk($sformatf("vec%0d.rf_key", i), 32'(rf_key), 32'(tbl[i].rf));
      chk($sformatf("vec%0d.m_tvalid", i), 32'(m_axis_tvalid), 32'(tbl[i].mv));
      chk($sformatf("vec%0d.s_tready", i), 32'(s_axis_tready), 32'(tbl[i].sr));
      tick();
    end

    // Drain: ptt drops on beat 3 of an 8-beat packet
    do_reset();
    beat = 0; passed = 0;
    for (int c = 0; c < 20; c++) begin
      tv = (c >= 5) && (beat < 8);
      drive(c < 7, tv, beat == 7, 1'b1, DW'(16'h100 + beat));
      if (m_axis_tvalid && m_axis_tready) passed++;
      if (tv && s_axis_tready) beat++;
      if (c == 8)  chk("drain.state_c8", 32'(state_o), 32'd3);
      if (c == 13) chk("drain.state_c13", 32'(state_o), 32'd4);
      if (c == 16) chk("drain.rf_key_c16", 32'(rf_key), 32'd1);
      if (c == 17) chk("drain.rf_key_c17", 32'(rf_key), 32'd0);
      tick();
    end
    chk("drain.beats", 32'(passed), 32'd8);

    // TOT with back-to-back 16-beat packets and ptt held
    do_reset();
    beat = 0;
    for (int c = 0; c < 48; c++) begin
      drive(c < 46, 1'b1, (beat % 16) == 15, 1'b1, DW'(beat));
      chk($sformatf("tot.state_c%0d", c), 32'(state_o), 32'(tot_seq_state(c)));
      chk($sformatf("tot.flag_c%0d", c), 32'(tot_expired), 32'(c >= 25 && c <= 46));
      if (s_axis_tready) beat++;
      tick();
    end
    chk("tot.beats", 32'(beat), 32'd32);

    // Asynchronous reset while streaming
    do_reset();
    for (int c = 0; c < 7; c++) begin
      drive(1'b1, 1'b1, 1'b0, 1'b1, DW'(c));
      tick();
    end
    drive(1'b1, 1'b1, 1'b0, 1'b1, 16'h5a5a);
    chk("midreset.pre_state", 32'(state_o), 32'd2);
    aresetn = 1'b0;
    model_reset();
    #1;
    chk("midreset.state", 32'(state_o), 32'd0);
    chk("midreset.rf_key", 32'(rf_key), 32'd0);
    chk("midreset.m_tvalid", 32'(m_axis_tvalid), 32'd0);
    chk("midreset.s_tready", 32'(s_axis_tready), 32'd0);
    @(negedge aclk);
    aresetn = 1'b1; ptt_en = 1'b0;
    tick();

    // Randomized traffic with a well-behaved upstream source and random backpressure
    do_reset();
    p = 1'b0; tv = 1'b0; tl = 1'b0; d = '0; acc = 1'b1;
    hold_prev = 1'b0; hold_data = '0; up_beats = 0; dn_beats = 0;
    for (int c = 0; c < 2500; c++) begin
      if ($urandom_range(0, 39) == 0) p = !p;
      if (acc || !tv) begin
        tv = ($urandom_range(0, 3) != 0);
        tl = ($urandom_range(0, 5) == 0);
        d  = DW'($urandom);
      end
      tr = ($urandom_range(0, 2) != 0);
      drive(p, tv, tl, tr, d);
      if (hold_prev && (m_phase == 2 || m_phase == 3)) begin
        chk("rand.hold_tvalid", 32'(m_axis_tvalid), 32'd1);
        chk("rand.hold_tdata", 32'(m_axis_tdata), 32'(hold_data));
      end
      hold_prev = m_axis_tvalid && !m_axis_tready;
      hold_data = m_axis_tdata;
      acc = tv && s_axis_tready;
      if (acc) up_beats++;
      if (m_axis_tvalid && m_axis_tready) dn_beats++;
      tick();
    end
    chk("rand.beat_count", 32'(dn_beats), 32'(up_beats));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
